// File: rtl/add_accumulator_if.sv
// add_accumulator_if
//   Bundles every non-clock, non-reset signal of the add_accumulator block:
//   the sample input handshake, the operand/result wires to and from the
//   external ripple adder, and the frame-result handshake.
//   slave  : the accumulator block itself (drives o_* signals)
//   master : the surrounding logic (upstream source, adder, downstream sink)
//   Parameters:
//     WIDTH - operand, accumulator and adder width
//     CNT_W - width of the carry-out and sample counters
interface add_accumulator_if #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
);
  logic             i_clear;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_data;
  logic             i_last;
  logic [WIDTH-1:0] o_add1;
  logic [WIDTH-1:0] o_add2;
  logic [WIDTH-1:0] i_sum;
  logic             i_carry;
  logic             o_res_valid;
  logic             i_res_ready;
  logic [WIDTH-1:0] o_result;
  logic [CNT_W-1:0] o_carry_cnt;
  logic [CNT_W-1:0] o_sample_cnt;

  modport slave (
    input  i_clear, i_valid, i_data, i_last, i_sum, i_carry, i_res_ready,
    output o_ready, o_add1, o_add2, o_res_valid, o_result, o_carry_cnt,
           o_sample_cnt
  );

  modport master (
    output i_clear, i_valid, i_data, i_last, i_sum, i_carry, i_res_ready,
    input  o_ready, o_add1, o_add2, o_res_valid, o_result, o_carry_cnt,
           o_sample_cnt
  );
endinterface

// File: rtl/add_accumulator.sv
// add_accumulator
//   Sequential frame accumulator wrapped around an external combinational
//   ripple adder (carry-in tied 0). Each accepted sample is registered, then
//   added to the accumulator in a single ADD cycle through the adder. When
//   the sample flagged as last has been added, the frame total, the number
//   of adds that produced a carry-out and the sample count are offered on a
//   valid/ready result port.
//   Ports:
//     i_clk - clock, rising edge
//     i_rst - asynchronous active-high reset
//     bus   - add_accumulator_if.slave:
//             i_clear              synchronous abort, beats everything but reset
//             i_valid/o_ready      sample handshake, i_data/i_last payload
//             o_add1/o_add2        adder operands (accumulator / sample reg)
//             i_sum/i_carry        adder result and carry-out
//             o_res_valid/i_res_ready  result handshake
//             o_result/o_carry_cnt/o_sample_cnt  frame result, held in DONE
module add_accumulator #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input logic          i_clk,
  input logic          i_rst,
  add_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sample_reg;
  logic             last_flag;
  logic [CNT_W-1:0] carry_cnt;
  logic [CNT_W-1:0] sample_cnt;

  logic             accept;
  logic             do_add;
  logic             frame_clear;

  // Next-state and per-cycle control decode. i_clear overrides every state;
  // frame_clear is shared by the abort path and the result handshake since
  // both wipe the frame bookkeeping the same way.
  always_comb begin
    next_state  = state;
    accept      = 1'b0;
    do_add      = 1'b0;
    frame_clear = 1'b0;
    if (bus.i_clear) begin
      next_state  = IDLE;
      frame_clear = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_valid) begin
            accept     = 1'b1;
            next_state = ADD;
          end
        end
        ADD: begin
          do_add     = 1'b1;
          next_state = last_flag ? DONE : IDLE;
        end
        DONE: begin
          if (bus.i_res_ready) begin
            frame_clear = 1'b1;
            next_state  = IDLE;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Datapath registers. The sample register is deliberately left alone on a
  // frame clear: it only feeds operand 2 and is overwritten on the next
  // accept, so zeroing it would buy nothing. Counters stop at all-ones.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc        <= '0;
      sample_reg <= '0;
      last_flag  <= 1'b0;
      carry_cnt  <= '0;
      sample_cnt <= '0;
    end else if (frame_clear) begin
      acc        <= '0;
      last_flag  <= 1'b0;
      carry_cnt  <= '0;
      sample_cnt <= '0;
    end else begin
      if (accept) begin
        sample_reg <= bus.i_data;
        last_flag  <= bus.i_last;
      end
      if (do_add) begin
        acc <= bus.i_sum;
        if (bus.i_carry && (carry_cnt != '1)) begin
          carry_cnt <= carry_cnt + 1'b1;
        end
        if (sample_cnt != '1) begin
          sample_cnt <= sample_cnt + 1'b1;
        end
      end
    end
  end

  // All outputs come straight from registers or the state decode, so the
  // adder operands and the result stay glitch-free in every state.
  assign bus.o_ready      = (state == IDLE);
  assign bus.o_res_valid  = (state == DONE);
  assign bus.o_add1       = acc;
  assign bus.o_add2       = sample_reg;
  assign bus.o_result     = acc;
  assign bus.o_carry_cnt  = carry_cnt;
  assign bus.o_sample_cnt = sample_cnt;

endmodule
